stage_d: RTL and testbench

Instruction decode stage for Polaris, directly downstream of `stage_f`. It accepts fetched 32-bit RV64I instruction words with their PCs into a small in-order queue. It decodes the head entry into register specifiers, a sign-extended 64-bit immediate and a format class, and presents the result to the execute stage over a valid/ready handshake. It absorbs execute back-pressure and discards queued work on a pipeline flush.

---
 rtl/polaris_pkg.sv | 31 +++
 rtl/inst_decoder.sv | 58 +++++
 rtl/stage_d.sv | 82 ++++++++
 tb/tb_stage_d.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/polaris_pkg.sv
// Shared Polaris decode definitions: RV64I major opcodes, decoded format class, XLEN.
package polaris_pkg;

    localparam int XLEN = 64;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_SYS = 3'd6,
        FMT_BAD = 3'd7
    } fmt_t;

endpackage

// File: rtl/inst_decoder.sv
// Combinational RV64I field/immediate/format decode of one instruction word.
// Latency: zero (pure combinational). Backpressure: none, no state.
// STAGE_D_ILLEGAL_EN enables illegal-encoding detection; otherwise illegal is tied to 0.
module inst_decoder
    import polaris_pkg::*;
(
    input  logic [31:0]     inst,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    fmt_t fmt_c;

    assign rd  = inst[11:7];
    assign rs1 = inst[19:15];
    assign rs2 = inst[24:20];
    assign fmt = fmt_c;

    // Every valid major opcode ends in 2'b11, so compressed words fall through to BAD.
    always_comb begin
        fmt_c = FMT_BAD;
        case (inst[6:0])
            OPC_OP, OPC_OP_32:                                fmt_c = FMT_R;
            OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR:    fmt_c = FMT_I;
            OPC_STORE:                                        fmt_c = FMT_S;
            OPC_BRANCH:                                       fmt_c = FMT_B;
            OPC_LUI, OPC_AUIPC:                               fmt_c = FMT_U;
            OPC_JAL:                                          fmt_c = FMT_J;
            OPC_SYSTEM, OPC_MISC_MEM:                         fmt_c = FMT_SYS;
            default:                                          fmt_c = FMT_BAD;
        endcase
    end

    always_comb begin
        imm = '0;
        case (fmt_c)
            FMT_I: imm = {{52{inst[31]}}, inst[31:20]};
            FMT_S: imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B: imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U: imm = {{32{inst[31]}}, inst[31:12], 12'b0};
            FMT_J: imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

`ifdef STAGE_D_ILLEGAL_EN
    logic bad_funct7;
    assign bad_funct7 = (fmt_c == FMT_R) && (inst[31:25] != 7'b0000000) && (inst[31:25] != 7'b0100000);
    assign illegal    = (fmt_c == FMT_BAD) || bad_funct7 || (inst == 32'h0) || (inst == 32'hFFFF_FFFF);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: rtl/stage_d.sv
// Polaris decode stage: in-order DEPTH-entry queue of fetched words, head decoded onto x_*.
// Latency: one cycle from accept to x_valid_o when empty; one instruction per cycle sustained.
// Backpressure: f_ready_o drops when full (no pass-through); flush empties the queue. STAGE_D_ILLEGAL_EN enables x_illegal_o.
module stage_d
    import polaris_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            f_valid_i,
    output logic            f_ready_o,
    input  logic [61:0]     f_pc_i,
    input  logic [31:0]     f_inst_i,
    input  logic            flush_i,
    output logic            x_valid_o,
    input  logic            x_ready_i,
    output logic [61:0]     x_pc_o,
    output logic [31:0]     x_inst_o,
    output logic [4:0]      x_rd_o,
    output logic [4:0]      x_rs1_o,
    output logic [4:0]      x_rs2_o,
    output logic [XLEN-1:0] x_imm_o,
    output logic [2:0]      x_fmt_o,
    output logic            x_illegal_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [61:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign f_ready_o = (count != CW'(DEPTH));
    assign x_valid_o = (count != '0);
    assign push      = f_valid_i & f_ready_o;
    assign pop       = x_valid_o & x_ready_i;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i && !flush_i && push) begin
            pc_mem[wr_ptr]   <= f_pc_i;
            inst_mem[wr_ptr] <= f_inst_i;
        end
    end

    assign x_pc_o   = pc_mem[rd_ptr];
    assign x_inst_o = inst_mem[rd_ptr];

    inst_decoder u_dec (
        .inst    (x_inst_o),
        .rd      (x_rd_o),
        .rs1     (x_rs1_o),
        .rs2     (x_rs2_o),
        .imm     (x_imm_o),
        .fmt     (x_fmt_o),
        .illegal (x_illegal_o)
    );

endmodule

// File: tb/tb_stage_d.sv
// Bench for stage_d: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_stage_d;

    localparam int DEPTH = 2;
    localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                           F_U = 3'd4, F_J = 3'd5, F_SYS = 3'd6, F_BAD = 3'd7;

    logic        clk = 1'b0;
    logic        reset_i, f_valid_i, flush_i, x_ready_i;
    logic [61:0] f_pc_i;
    logic [31:0] f_inst_i;
    logic        f_ready_o, x_valid_o, x_illegal_o;
    logic [61:0] x_pc_o;
    logic [31:0] x_inst_o;
    logic [4:0]  x_rd_o, x_rs1_o, x_rs2_o;
    logic [63:0] x_imm_o;
    logic [2:0]  x_fmt_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [61:0] pc;
        logic [31:0] inst;
    } ent_t;
    ent_t model_q[$];
    bit   model_known = 0;

    always #5 clk = ~clk;

    stage_d #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .f_valid_i(f_valid_i), .f_ready_o(f_ready_o), .f_pc_i(f_pc_i), .f_inst_i(f_inst_i),
        .flush_i(flush_i),
        .x_valid_o(x_valid_o), .x_ready_i(x_ready_i), .x_pc_o(x_pc_o), .x_inst_o(x_inst_o),
        .x_rd_o(x_rd_o), .x_rs1_o(x_rs1_o), .x_rs2_o(x_rs2_o),
        .x_imm_o(x_imm_o), .x_fmt_o(x_fmt_o), .x_illegal_o(x_illegal_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Format from the RISC-V major-opcode map, indexed by inst[6:2].
    function automatic logic [2:0] ref_fmt(input logic [31:0] w);
        if (w[1:0] != 2'b11) return F_BAD;
        case (int'(w[6:2]))
            'h0C, 'h0E:             return F_R;
            'h04, 'h06, 'h00, 'h19: return F_I;
            'h08:                   return F_S;
            'h18:                   return F_B;
            'h0D, 'h05:             return F_U;
            'h1B:                   return F_J;
            'h1C, 'h03:             return F_SYS;
            default:                return F_BAD;
        endcase
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] w);
        longint s = longint'($signed(w));
        case (ref_fmt(w))
            F_I: return s >>> 20;
            F_S: return ((s >>> 25) << 5) | longint'(w[11:7]);
            F_B: return ((s >>> 31) << 12) | (longint'(w[7]) << 11)
                        | (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
            F_U: return (s >>> 12) << 12;
            F_J: return ((s >>> 31) << 20) | (longint'(w[19:12]) << 12)
                        | (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic ref_ill(input logic [31:0] w);
`ifdef STAGE_D_ILLEGAL_EN
        logic [6:0] f7 = w[31:25];
        return (ref_fmt(w) == F_BAD) || (w == 32'h0) || (w == 32'hFFFF_FFFF)
               || (ref_fmt(w) == F_R && f7 != 7'h00 && f7 != 7'h20);
`else
        return 1'b0;
`endif
    endfunction

    task automatic compare_outputs();
        ent_t h;
        if (!model_known) return;
        check("x_valid", 64'(x_valid_o), 64'(model_q.size() != 0));
        check("f_ready", 64'(f_ready_o), 64'(model_q.size() != DEPTH));
        if (model_q.size() != 0) begin
            h = model_q[0];
            check("x_pc",      64'(x_pc_o),      64'(h.pc));
            check("x_inst",    64'(x_inst_o),    64'(h.inst));
            check("x_rd",      64'(x_rd_o),      64'(h.inst[11:7]));
            check("x_rs1",     64'(x_rs1_o),     64'(h.inst[19:15]));
            check("x_rs2",     64'(x_rs2_o),     64'(h.inst[24:20]));
            check("x_imm",     x_imm_o,          ref_imm(h.inst));
            check("x_fmt",     64'(x_fmt_o),     64'(ref_fmt(h.inst)));
            check("x_illegal", 64'(x_illegal_o), 64'(ref_ill(h.inst)));
        end
    endtask

    // Called at a falling edge: check, drive, advance the model to the next rising edge.
    task automatic cycle(input logic rst_n, input logic fv, input logic [61:0] pc,
                         input logic [31:0] w, input logic xr, input logic fl);
        bit do_pop, do_push;
        compare_outputs();
        reset_i = rst_n; f_valid_i = fv; f_pc_i = pc; f_inst_i = w;
        x_ready_i = xr; flush_i = fl;
        if (!rst_n || fl) begin
            model_q.delete();
            model_known = 1;
        end else begin
            do_pop  = (model_q.size() != 0) && xr;
            do_push = fv && (model_q.size() != DEPTH);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back('{pc: pc, inst: w});
        end
        @(negedge clk);
    endtask

    logic [6:0] opc_tab [13] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                                 7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};

    function automatic logic [31:0] rand_inst();
        logic [31:0] w = $urandom;
        int sel = $urandom_range(0, 19);
        if (sel < 15)       w[6:0] = opc_tab[$urandom_range(0, 12)];
        else if (sel == 15) w = 32'h0;
        else if (sel == 16) w = 32'hFFFF_FFFF;
        else if (sel == 17) begin w[6:0] = 7'h33; w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
        return w;
    endfunction

    localparam logic [61:0] PC0 = 62'h3FFF_FFFF_FFFF_FFC0;

    initial begin
        reset_i = 1'b0; f_valid_i = 1'b0; f_pc_i = '0; f_inst_i = '0;
        x_ready_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);

        cycle(0, 0, 0, 0, 0, 0);
        check("rst_x_valid", 64'(x_valid_o), 64'd0);
        check("rst_f_ready", 64'(f_ready_o), 64'd1);

        cycle(1, 1, PC0, 32'h0050_0093, 1, 0);
        check("addi_valid", 64'(x_valid_o), 64'd1);
        check("addi_fmt",   64'(x_fmt_o),   64'(F_I));
        check("addi_rd",    64'(x_rd_o),    64'd1);
        check("addi_rs1",   64'(x_rs1_o),   64'd0);
        check("addi_imm",   x_imm_o,        64'd5);
        check("addi_pc",    64'(x_pc_o),    64'(64'hFFFF_FFFF_FFFF_FF00 >> 2));

        cycle(1, 1, PC0 + 1, 32'hFE00_0EE3, 1, 0);
        check("beq_fmt", 64'(x_fmt_o), 64'(F_B));
        check("beq_imm", x_imm_o,      64'hFFFF_FFFF_FFFF_FFFC);

        cycle(1, 1, PC0 + 2, 32'h1234_52B7, 1, 0);
        check("lui_fmt", 64'(x_fmt_o), 64'(F_U));
        check("lui_rd",  64'(x_rd_o),  64'd5);
        check("lui_imm", x_imm_o,      64'h0000_0000_1234_5000);

        cycle(1, 0, 0, 0, 1, 0);

        // Back-pressure: third word must be refused and then drain in order.
        cycle(1, 1, 62'h100, 32'h0010_0113, 0, 0);
        cycle(1, 1, 62'h101, 32'h0020_0193, 0, 0);
        check("full_f_ready", 64'(f_ready_o), 64'd0);
        cycle(1, 1, 62'h102, 32'h0030_0213, 0, 0);
        check("hold_pc", 64'(x_pc_o), 64'h100);
        cycle(1, 1, 62'h102, 32'h0030_0213, 1, 0);
        check("drain1_pc", 64'(x_pc_o), 64'h101);
        cycle(1, 1, 62'h102, 32'h0030_0213, 1, 0);
        check("drain2_pc", 64'(x_pc_o), 64'h102);
        cycle(1, 0, 0, 0, 1, 0);
        check("drained", 64'(x_valid_o), 64'd0);

        // Flush with an incoming word: all dropped.
        cycle(1, 1, 62'h200, 32'h0000_0013, 0, 0);
        cycle(1, 1, 62'h201, 32'h0000_0013, 0, 0);
        cycle(1, 1, 62'h202, 32'h0000_0013, 0, 1);
        check("flush_valid", 64'(x_valid_o), 64'd0);
        cycle(1, 1, 62'h203, 32'h0000_0000, 0, 0);
        check("zero_fmt", 64'(x_fmt_o), 64'(F_BAD));
`ifdef STAGE_D_ILLEGAL_EN
        check("zero_illegal", 64'(x_illegal_o), 64'd1);
`else
        check("zero_illegal", 64'(x_illegal_o), 64'd0);
`endif
        cycle(1, 0, 0, 0, 1, 0);

        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 3) != 0),
                  {$urandom, $urandom},
                  rand_inst(),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 24) == 0));
        end
        compare_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
